// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with bounded hold and a one-cycle all-OE-low turnaround.
// Grant two edges after request from idle; outputs are combinational from registered state; rdata/rvalid lag the pins by one cycle.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     wr,
  input  logic [8*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          rdata,
  output logic                rvalid,
  output logic                busy,
  input  logic [7:0]          uio_in,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            owner_wr_q, owner_wr_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]      rdata_q;
  logic            rvalid_q;

  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] others;
  logic [IW:0]     pick_idle;
  logic [IW:0]     pick_rel;

  // Returns {found, index} of the first set bit scanning upward from last+1, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW:0]   res;
    logic [IW-1:0] sel;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sel = IW'((int'(last) + k) % NREQ);
      if (r[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  assign owner_oh  = NREQ'(1) << owner_q;
  assign others    = req & ~owner_oh;
  assign pick_idle = rr_pick(req, rr_ptr_q);
  // rr_ptr equals the owner while in OWN, so this places the current owner last.
  assign pick_rel  = rr_pick(others, owner_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_wr_d = owner_wr_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt        = '0;
    uio_oe     = 8'h00;
    uio_out    = 8'h00;
    case (state_q)
      IDLE: begin
        if (pick_idle[IW]) begin
          owner_d    = pick_idle[IW-1:0];
          owner_wr_d = wr[pick_idle[IW-1:0]];
          state_d    = TURN;
        end
      end
      TURN: begin
        state_d    = OWN;
        hold_cnt_d = '0;
        rr_ptr_d   = owner_q;
      end
      OWN: begin
        gnt = owner_oh;
        if (owner_wr_q) begin
          uio_oe  = 8'hFF;
          uio_out = wdata[{owner_q, 3'b000} +: 8];
        end
        if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
        if (!req[owner_q] || ((hold_cnt_q == HOLD_LAST) && (|others))) begin
          if (pick_rel[IW]) begin
            owner_d    = pick_rel[IW-1:0];
            owner_wr_d = wr[pick_rel[IW-1:0]];
            state_d    = TURN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_wr_q <= 1'b0;
      rr_ptr_q   <= IW'(NREQ - 1);
      hold_cnt_q <= '0;
      rdata_q    <= 8'h00;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_wr_q <= owner_wr_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      rdata_q    <= uio_in;
      rvalid_q   <= (state_q == OWN) && !owner_wr_q;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Randomized and directed stimulus for uio_bus_arbiter against a transaction-level model.
// Expected outputs are queued per cycle and checked by an independent monitor on the falling edge.
module tb_uio_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req, wr, gnt;
  logic [8*NREQ-1:0]   wdata;
  logic [7:0]          rdata, uio_in, uio_out, uio_oe;
  logic                rvalid, busy;

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata), .gnt(gnt),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [7:0]      oe;
    logic [7:0]      out;
    logic [7:0]      rd;
    logic            rv;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner as an integer (-1 = nobody), count of granted cycles.
  int              m_owner = -1;
  bit              m_turn  = 0;
  int              m_next  = 0;
  bit              m_wr    = 0;
  int              m_last  = NREQ - 1;
  int              m_done  = 0;
  logic [7:0]      m_rd    = 8'h00;
  bit              m_rv    = 0;
  logic [NREQ-1:0] one     = 1;

  function automatic int rr_next(input logic [NREQ-1:0] r, input int after);
    for (int k = 1; k <= NREQ; k++)
      if (r[(after + k) % NREQ]) return (after + k) % NREQ;
    return -1;
  endfunction

  task automatic model_step();
    logic [NREQ-1:0] oth;
    int              w;
    if (rst) begin
      m_owner = -1; m_turn = 0; m_wr = 0; m_last = NREQ - 1; m_done = 0;
      m_rd = 8'h00; m_rv = 0;
      return;
    end
    m_rv = (m_owner >= 0) && !m_wr;
    m_rd = uio_in;
    if (m_turn) begin
      m_turn = 0; m_owner = m_next; m_last = m_owner; m_done = 0;
    end else if (m_owner >= 0) begin
      m_done++;
      oth = req & ~(one << m_owner);
      if (!req[m_owner] || (m_done >= MAX_HOLD && oth != 0)) begin
        w = rr_next(oth, m_owner);
        m_owner = -1;
        if (w >= 0) begin
          m_next = w; m_wr = wr[w]; m_turn = 1;
        end
      end
    end else begin
      w = rr_next(req, m_last);
      if (w >= 0) begin
        m_next = w; m_wr = wr[w]; m_turn = 1;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.rd   = m_rd;
    e.rv   = m_rv;
    e.busy = (m_owner >= 0) || m_turn;
    if (m_owner >= 0) begin
      e.gnt = one << m_owner;
      if (m_wr) begin
        e.oe  = 8'hFF;
        e.out = wdata[8*m_owner +: 8];
      end
    end
    return e;
  endfunction

  // Modes: 0 reset, 1 single writer 2, 2 idle, 3 contention 1011, 4 reader 1,
  // 5 all request, 6 one-cycle pulse on 1, 7 random, 8 writer 3 at FF, 9 req 1001.
  task automatic gen(input int mode, input int c);
    rst    = 1'b0;
    wdata  = {$urandom, $urandom};
    uio_in = 8'($urandom);
    case (mode)
      0: begin rst = 1'b1; req = 4'hF; wr = 4'($urandom); end
      1: begin req = 4'b0100; wr = 4'b0100; wdata[23:16] = 8'hA5; end
      2: begin req = 4'b0000; wr = 4'($urandom); end
      3: begin req = 4'b1011; wr = 4'($urandom); end
      4: begin req = 4'b0010; wr = 4'b0000; uio_in = 8'h3C; end
      5: begin req = 4'hF; wr = 4'($urandom); end
      6: begin req = (c == 0) ? 4'b0010 : 4'b0000; wr = (c % 2 == 0) ? 4'b0000 : 4'b0010; end
      7: begin
        if ($urandom_range(0, 2) == 0) req = req ^ (one << $urandom_range(0, NREQ - 1));
        wr  = 4'($urandom);
        rst = ($urandom_range(0, 99) == 0);
      end
      8: begin req = 4'b1000; wr = 4'b1000; wdata[31:24] = 8'hFF; end
      9: begin req = 4'b1001; wr = 4'($urandom); end
      default: req = 4'b0000;
    endcase
  endtask

  int ph_mode[] = '{0, 5, 2, 1, 2, 3, 2, 4, 2, 8, 0, 9, 2, 6, 2, 7, 2};
  int ph_len[]  = '{2, 6, 4, 30, 4, 60, 4, 12, 4, 6, 1, 25, 4, 8, 4, 1500, 20};

  initial begin
    rst = 1'b1; req = 4'hF; wr = 4'h0; wdata = '0; uio_in = 8'h00;
    for (int p = 0; p < ph_mode.size(); p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        @(posedge clk);
        model_step();
        #1;
        gen(ph_mode[p], c);
        exp_q.push_back(model_out());
      end
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",     32'(gnt),     32'(e.gnt));
        chk("uio_oe",  32'(uio_oe),  32'(e.oe));
        chk("uio_out", 32'(uio_out), 32'(e.out));
        chk("rdata",   32'(rdata),   32'(e.rd));
        chk("rvalid",  32'(rvalid),  32'(e.rv));
        chk("busy",    32'(busy),    32'(e.busy));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("oe_needs_gnt", 32'((uio_oe == 8'h00) || (gnt != '0)), 32'd1);
        chk("oe_all_or_none", 32'((uio_oe == 8'h00) || (uio_oe == 8'hFF)), 32'd1);
      end
    end
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

- Shares the 8-bit bidirectional uio pad bus (uio_in / uio_out / uio_oe) between NREQ internal requesters.
- Sits between the user logic and the top-level uio pins.
- Arbitration is round-robin with a bounded hold time.
- Inserts one turnaround cycle with all output enables low between owners, so no two drivers ever overlap.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- MAX_HOLD, 16: maximum cycles an owner keeps the bus while another requester waits (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester bus request; level, held high while the bus is wanted.
- wr  in  NREQ  per-requester direction: 1 = drive pins, 0 = read pins. Sampled only at winner selection.
- wdata  in  8*NREQ  per-requester drive data; slice i = wdata[8i+7:8i].
- gnt  out  NREQ  one-hot grant; all zero when no owner.
- rdata  out  8  uio_in, registered every cycle.
- rvalid  out  1  rdata was captured while a read-owner held the bus.
- busy  out  1  state ≠ IDLE.
- uio_in  in  8  pad input.
- uio_out  out  8  pad output data.
- uio_oe  out  8  pad output enable; 8'hFF or 8'h00 only.

## Operation

- **State registers:** state ∈ {IDLE, TURN, OWN}, owner index, owner_wr, rr_ptr (last owner), hold_cnt.
- **Winner selection:** first asserted req scanning from rr_ptr+1 upward, modulo NREQ. At selection, owner and owner_wr = wr[winner] are latched.
- **IDLE:**
  - If any req: select winner, go TURN.
  - Else stay IDLE.
- **TURN:**
  - Lasts exactly 1 cycle. gnt = 0, uio_oe = 0.
  - Next state is OWN; hold_cnt cleared to 0; rr_ptr ← owner.
  - req[owner] dropping during TURN is ignored; the grant still occurs for ≥1 cycle.
- **OWN:**
  - gnt[owner] = 1.
  - If owner_wr: uio_oe = 8'hFF and uio_out = wdata[owner], combinational from the current wdata.
  - Else: uio_oe = 0 and uio_out = 0.
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
- **Release from OWN:** triggered if req[owner] = 0, or if (hold_cnt == MAX_HOLD-1 and any other req is high).
  - On release, if any other requester is pending: select winner (excluding the current owner), go TURN.
  - Otherwise go IDLE.
  - A released owner that still requests re-enters arbitration normally. Round-robin places it last.
- **Sole requester:** no preemption, regardless of hold_cnt.
- **Direction:** changing wr mid-grant has no effect until the next grant.
- **Outputs outside OWN:** gnt = 0, uio_oe = 0, uio_out = 0.
- **Read path:**
  - rdata ← uio_in every cycle.
  - rvalid ← (state == OWN && !owner_wr).
- **Reset (any cycle, including mid-OWN):** next edge gives state = IDLE, gnt = 0, uio_oe = 0, uio_out = 0, rdata = 0, rvalid = 0, hold_cnt = 0, owner = 0, owner_wr = 0, rr_ptr = NREQ-1. After reset, requester 0 has top priority.

## Timing

- **Grant latency:** req sampled high at edge E (bus idle), TURN during E..E+1, gnt high from edge E+1+1.
  - That is, gnt rises 2 edges after req is first sampled.
- **Release:** req low sampled at edge K means gnt is low after edge K. The owner's last driven cycle is the one ending at K.
- **Handover:** old owner's last OWN cycle, then exactly 1 TURN cycle with uio_oe = 0, then the new owner's gnt.
- **Maximum bus hold under contention:** exactly MAX_HOLD cycles of gnt.
- **Worst-case wait for a requester:** (NREQ-1)·(MAX_HOLD+1)+1 cycles from TURN entry.
- **Read latency:** rdata/rvalid reflect the pins 1 cycle later. The first rvalid follows the first OWN cycle; the last rvalid follows the last OWN cycle.
- **Invariants (every cycle):**
  - gnt is one-hot or zero.
  - uio_oe ≠ 0 implies gnt ≠ 0.

## Test plan

- **Reset:** hold rst 2 cycles with req = 4'hF → gnt = 0, uio_oe = 0, rvalid = 0. After release, first gnt = 4'b0001 exactly 2 edges later.
- **Single write owner:** req[2] = 1, wr[2] = 1, wdata[2] = 8'hA5 for 30 cycles → gnt = 4'b0100 for 28 cycles, uio_oe = 8'hFF, uio_out = 8'hA5. No preemption. gnt falls 1 edge after req drops.
- **Contention:** req = 4'b1011 held continuously, MAX_HOLD = 16 → grant order 0, 1, 3, 0, … Each gnt lasts 16 cycles, separated by 1 cycle of gnt = 0 and uio_oe = 0.
- **Read owner:** req[1] = 1, wr[1] = 0, uio_in = 8'h3C → uio_oe = 0. rdata = 8'h3C with rvalid = 1 one cycle after each OWN cycle. rvalid = 0 after release.
- **Mid-operation:**
  - Assert rst while requester 3 drives 8'hFF → next edge uio_oe = 0, gnt = 0.
  - Then req = 4'b1000 → grant after 2 edges; rr_ptr restarted, so req = 4'b1001 grants 0 first.
- **Early drop:** req[1] pulses 1 cycle (sampled at E), wr[1] toggled during OWN → 1 cycle of gnt[1] after TURN. Direction stays as latched; back to IDLE.
